mem_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline. It consumes the E/M pipeline register bundle (`M_*` signals), performs word loads and stores against a local data memory, and resolves W→M store-data forwarding. It also owns the M/W pipeline register that feeds register-file write-back.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/dm_ram.sv | 29 ++
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: decode-bus bit positions and reset PC.
package mips_pkg;

    localparam int IB_W     = 28;

    localparam int IB_CAL_R = 27;
    localparam int IB_CAL_I = 26;
    localparam int IB_CAL_L = 25;
    localparam int IB_CAL_S = 24;
    localparam int IB_CAL_B = 23;
    localparam int IB_CAL_M = 22;
    localparam int IB_ADDU  = 21;
    localparam int IB_SUBU  = 20;
    localparam int IB_ORI   = 19;
    localparam int IB_LW    = 18;
    localparam int IB_SW    = 17;
    localparam int IB_BEQ   = 16;
    localparam int IB_LUI   = 15;
    localparam int IB_J     = 14;
    localparam int IB_JAL   = 13;
    localparam int IB_JR    = 12;
    localparam int IB_NOP   = 11;
    localparam int IB_YNEW  = 10;
    localparam int IB_ADD   = 9;
    localparam int IB_SUB   = 8;
    localparam int IB_ANDX  = 7;
    localparam int IB_ORX   = 6;
    localparam int IB_XORX  = 5;
    localparam int IB_NORX  = 4;
    localparam int IB_ADDI  = 3;
    localparam int IB_ADDIU = 2;
    localparam int IB_ANDI  = 1;
    localparam int IB_XORI  = 0;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

endpackage

// File: rtl/dm_ram.sv
// Word-addressed data memory: asynchronous read, synchronous write,
// asynchronous clear of every word.
module dm_ram #(
    parameter int WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // Clear all words on reset; otherwise commit one word per enabled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: word load/store against local data memory, W->M store-data
// forwarding, and the M/W pipeline register.
module mem_stage #(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  M_a2,
    input  logic [4:0]  M_a3,
    input  logic [31:0] M_vin,
    input  logic [31:0] M_aluo,
    input  logic        M_grf_en,
    input  logic        M_dm_en,
    input  logic [31:0] M_pc,
    input  logic [27:0] M_instrbus,
    output logic [31:0] M_fwd,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] W_vin,
    output logic [4:0]  W_a3,
    output logic        W_grf_en,
    output logic [31:0] W_pc,
    output logic [27:0] W_instrbus
);

    import mips_pkg::*;

    localparam int          AW       = $clog2(DM_WORDS);
    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

    logic          is_load;
    logic          is_store;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          fwd_hit;
    logic [31:0]   store_data;
    logic [31:0]   ram_rdata;
    logic [31:0]   wb_value;

    assign is_load  = M_instrbus[IB_CAL_L];
    assign is_store = M_instrbus[IB_CAL_S];

    // Compare in 33 bits so a full 4 GiB memory would not overflow the bound.
    assign in_range = ({1'b0, M_aluo} < DM_BYTES);
    assign idx      = M_aluo[AW+1:2];

    // $0 is hard-wired to zero, so a pending write to it must never forward.
    assign fwd_hit    = W_grf_en && (W_a3 != 5'd0) && (W_a3 == M_a2);
    assign store_data = fwd_hit ? W_vin : M_vin;

    assign dm_we    = M_dm_en && is_store && in_range;
    assign dm_addr  = {M_aluo[31:2], 2'b00};
    assign dm_wdata = store_data;

    dm_ram #(
        .WORDS (DM_WORDS)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .we    (dm_we),
        .addr  (idx),
        .wdata (store_data),
        .rdata (ram_rdata)
    );

    assign wb_value = is_load ? (in_range ? ram_rdata : 32'd0) : M_vin;

    // A load's value is not known until W, so it is never forwarded from M.
    assign M_fwd = (M_grf_en && !is_load) ? M_vin : 32'd0;

    // M/W pipeline register; advances every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            W_vin      <= '0;
            W_a3       <= '0;
            W_grf_en   <= 1'b0;
            W_pc       <= PC_RESET;
            W_instrbus <= '0;
        end else begin
            W_vin      <= wb_value;
            W_a3       <= M_a3;
            W_grf_en   <= M_grf_en;
            W_pc       <= M_pc;
            W_instrbus <= M_instrbus;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a reference memory/W-register model
// predicts each result, which is queued at drive time and compared in W.
module tb_mem_stage;

    localparam int          DM_WORDS = 1024;
    localparam logic [31:0] PC_RST   = 32'h0000_3000;

    localparam logic [27:0] IB_LWX  = (28'd1 << 25) | (28'd1 << 18);
    localparam logic [27:0] IB_SWX  = (28'd1 << 24) | (28'd1 << 17);
    localparam logic [27:0] IB_ADDX = (28'd1 << 27) | (28'd1 << 21);
    localparam logic [27:0] IB_JALX = (28'd1 << 13);
    localparam logic [27:0] IB_ORIX = (28'd1 << 26) | (28'd1 << 19);

    logic        clk;
    logic        reset;
    logic [4:0]  M_a2;
    logic [4:0]  M_a3;
    logic [31:0] M_vin;
    logic [31:0] M_aluo;
    logic        M_grf_en;
    logic        M_dm_en;
    logic [31:0] M_pc;
    logic [27:0] M_instrbus;
    logic [31:0] M_fwd;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] W_vin;
    logic [4:0]  W_a3;
    logic        W_grf_en;
    logic [31:0] W_pc;
    logic [27:0] W_instrbus;

    mem_stage #(
        .DM_WORDS (DM_WORDS),
        .PC_RESET (PC_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .M_a2       (M_a2),
        .M_a3       (M_a3),
        .M_vin      (M_vin),
        .M_aluo     (M_aluo),
        .M_grf_en   (M_grf_en),
        .M_dm_en    (M_dm_en),
        .M_pc       (M_pc),
        .M_instrbus (M_instrbus),
        .M_fwd      (M_fwd),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .W_vin      (W_vin),
        .W_a3       (W_a3),
        .W_grf_en   (W_grf_en),
        .W_pc       (W_pc),
        .W_instrbus (W_instrbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] vin;
        logic [4:0]  a3;
        logic        grf;
        logic [31:0] pc;
        logic [27:0] ib;
    } wexp_t;

    wexp_t       sb_q [$];
    wexp_t       mw;
    logic [31:0] mem_m [DM_WORDS];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DM_WORDS; i++) mem_m[i] = '0;
        mw.vin = '0; mw.a3 = '0; mw.grf = 1'b0; mw.pc = PC_RST; mw.ib = '0;
        sb_q.delete();
    endtask

    // Drive one instruction into M just after an edge, check the combinational
    // outputs mid-cycle, then check the M/W register after the next edge.
    task automatic step(input string tag, input logic [27:0] ib, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [31:0] vin, input logic [31:0] aluo,
                        input logic grf_en, input logic dm_en, input logic [31:0] pc);
        logic          ld, st, inr, hit, we_e;
        logic [9:0]    ix;
        logic [31:0]   sd;
        wexp_t         e, got;
        ld   = ib[25];
        st   = ib[24];
        inr  = (aluo < 32'(DM_WORDS * 4));
        ix   = aluo[11:2];
        hit  = mw.grf && (mw.a3 != 5'd0) && (mw.a3 == a2);
        sd   = hit ? mw.vin : vin;
        we_e = dm_en && st && inr;
        e.vin = ld ? (inr ? mem_m[ix] : 32'd0) : vin;
        e.a3 = a3; e.grf = grf_en; e.pc = pc; e.ib = ib;

        M_instrbus = ib; M_a2 = a2; M_a3 = a3; M_vin = vin; M_aluo = aluo;
        M_grf_en = grf_en; M_dm_en = dm_en; M_pc = pc;
        sb_q.push_back(e);
        #2;
        chk({tag, ".dm_we"}, 32'(dm_we), 32'(we_e));
        chk({tag, ".M_fwd"}, M_fwd, (grf_en && !ld) ? vin : 32'd0);
        if (st) begin
            chk({tag, ".dm_wdata"}, dm_wdata, sd);
            chk({tag, ".dm_addr"}, dm_addr, {aluo[31:2], 2'b00});
        end
        @(posedge clk);
        if (we_e) mem_m[ix] = sd;
        mw = e;
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, ".W_vin"}, W_vin, got.vin);
            chk({tag, ".W_a3"}, 32'(W_a3), 32'(got.a3));
            chk({tag, ".W_grf_en"}, 32'(W_grf_en), 32'(got.grf));
            chk({tag, ".W_pc"}, W_pc, got.pc);
            chk({tag, ".W_instrbus"}, 32'(W_instrbus), 32'(got.ib));
        end
    endtask

    initial begin
        reset = 1'b1;
        M_a2 = '0; M_a3 = '0; M_vin = '0; M_aluo = '0; M_grf_en = 1'b0;
        M_dm_en = 1'b0; M_pc = '0; M_instrbus = '0;
        model_reset();

        // Reset with no clock edge yet
        #2;
        chk("rst.W_pc", W_pc, PC_RST);
        chk("rst.W_vin", W_vin, 32'd0);
        chk("rst.W_a3", 32'(W_a3), 32'd0);
        chk("rst.W_grf_en", 32'(W_grf_en), 32'd0);
        chk("rst.W_instrbus", 32'(W_instrbus), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        mw.vin = '0; mw.a3 = '0; mw.grf = 1'b0; mw.pc = '0; mw.ib = '0;
        #1;

        step("lw5", IB_LWX, 5'd0, 5'd3, 32'h0, 32'h14, 1'b1, 1'b0, 32'h3000);
        chk("lw5.zero", W_vin, 32'd0);

        // Store then load, same word, consecutive cycles
        step("sw10", IB_SWX, 5'd4, 5'd0, 32'hDEADBEEF, 32'h10, 1'b0, 1'b1, 32'h3004);
        step("lw10", IB_LWX, 5'd0, 5'd8, 32'h0, 32'h10, 1'b1, 1'b0, 32'h3008);
        chk("lw10.data", W_vin, 32'hDEADBEEF);
        chk("lw10.a3", 32'(W_a3), 32'd8);

        // lw -> sw on same rt: forwarded from W
        step("lw_a", IB_LWX, 5'd0, 5'd10, 32'h0, 32'h11, 1'b1, 1'b0, 32'h300C);
        step("sw_fl", IB_SWX, 5'd10, 5'd0, 32'h0BAD0BAD, 32'h44, 1'b0, 1'b1, 32'h3010);
        step("lw44", IB_LWX, 5'd0, 5'd11, 32'h0, 32'h44, 1'b1, 1'b0, 32'h3014);
        chk("lw44.data", W_vin, 32'hDEADBEEF);

        // Forwarding from an ALU result in W
        step("addu9", IB_ADDX, 5'd0, 5'd9, 32'h1234, 32'h1234, 1'b1, 1'b0, 32'h3018);
        step("sw_f9", IB_SWX, 5'd9, 5'd0, 32'hFFFF, 32'h40, 1'b0, 1'b1, 32'h301C);
        step("lw40", IB_LWX, 5'd0, 5'd12, 32'h0, 32'h40, 1'b1, 1'b0, 32'h3020);
        chk("lw40.data", W_vin, 32'h1234);

        // $0 in W is never forwarded
        step("ori0", IB_ORIX, 5'd0, 5'd0, 32'h5678, 32'h5678, 1'b1, 1'b0, 32'h3024);
        step("sw_f0", IB_SWX, 5'd0, 5'd0, 32'hFFFF, 32'h48, 1'b0, 1'b1, 32'h3028);
        step("lw48", IB_LWX, 5'd0, 5'd13, 32'h0, 32'h48, 1'b1, 1'b0, 32'h302C);
        chk("lw48.data", W_vin, 32'hFFFF);

        // Out of range: index aliases word 0, which must stay untouched
        step("sw0", IB_SWX, 5'd0, 5'd0, 32'h11111111, 32'h0, 1'b0, 1'b1, 32'h3030);
        step("sw_oor", IB_SWX, 5'd0, 5'd0, 32'h99999999, 32'(DM_WORDS * 4), 1'b0, 1'b1, 32'h3034);
        step("lw0", IB_LWX, 5'd0, 5'd14, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3038);
        chk("lw0.kept", W_vin, 32'h11111111);
        step("lw_oor", IB_LWX, 5'd0, 5'd15, 32'hABCD, 32'(DM_WORDS * 4), 1'b1, 1'b0, 32'h303C);
        chk("lw_oor.zero", W_vin, 32'd0);
        step("lw_top", IB_LWX, 5'd0, 5'd15, 32'h0, 32'(DM_WORDS * 4 - 4), 1'b1, 1'b0, 32'h3040);

        // Pass-through jal
        step("jal", IB_JALX, 5'd0, 5'd31, 32'h3008, 32'h0, 1'b1, 1'b0, 32'h3000);
        chk("jal.vin", W_vin, 32'h3008);
        chk("jal.grf", 32'(W_grf_en), 32'd1);

        // Reset mid-cycle with a store in M
        M_instrbus = IB_SWX; M_a2 = 5'd0; M_a3 = 5'd0; M_vin = 32'hCAFEF00D;
        M_aluo = 32'h20; M_grf_en = 1'b0; M_dm_en = 1'b1; M_pc = 32'h3044;
        #2;
        reset = 1'b1;
        #1;
        chk("mrst.W_pc", W_pc, PC_RST);
        chk("mrst.W_vin", W_vin, 32'd0);
        chk("mrst.W_a3", 32'(W_a3), 32'd0);
        chk("mrst.W_grf_en", 32'(W_grf_en), 32'd0);
        chk("mrst.W_instrbus", 32'(W_instrbus), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("mrst.hold_pc", W_pc, PC_RST);
        @(negedge clk);
        M_instrbus = '0; M_a2 = '0; M_a3 = '0; M_vin = '0; M_aluo = '0;
        M_grf_en = 1'b0; M_dm_en = 1'b0; M_pc = '0;
        reset = 1'b0;
        @(posedge clk);
        mw.vin = '0; mw.a3 = '0; mw.grf = 1'b0; mw.pc = '0; mw.ib = '0;
        #1;
        step("lw20", IB_LWX, 5'd0, 5'd16, 32'h0, 32'h20, 1'b1, 1'b0, 32'h3048);
        chk("lw20.blocked", W_vin, 32'd0);
        step("lw10c", IB_LWX, 5'd0, 5'd17, 32'h0, 32'h10, 1'b1, 1'b0, 32'h304C);
        chk("lw10c.cleared", W_vin, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
